// File: rtl/rst_seq.sv
// ============================================================================
//  Module   : rst_seq
//  Brief    : Lock-qualified staged reset sequencer (DDR2 -> CPU -> peripherals)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rst_seq #(
    parameter int STABLE_CYCLES = 1024,
    parameter int STAGE_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 65536
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       pll_locked_i,
    input  logic       dcm_locked_i,
    input  logic       sw_rst_req_i,
    output logic       ddr2_rst_o,
    output logic       cpu_rst_o,
    output logic       periph_rst_o,
    output logic       rst_done_o,
    output logic       lock_timeout_o,
    output logic [7:0] loss_cnt_o
);

    localparam int c_max_ab    = (STABLE_CYCLES > STAGE_CYCLES) ? STABLE_CYCLES : STAGE_CYCLES;
    localparam int c_max_param = (c_max_ab > LOCK_TIMEOUT) ? c_max_ab : LOCK_TIMEOUT;
    localparam int c_cw        = (c_max_param > 1) ? $clog2(c_max_param) : 1;

    localparam logic [c_cw-1:0] c_stable_last = c_cw'(STABLE_CYCLES - 1);
    localparam logic [c_cw-1:0] c_stage_last  = c_cw'(STAGE_CYCLES - 1);
    localparam logic [c_cw-1:0] c_tmo_last    = c_cw'(LOCK_TIMEOUT - 1);
    localparam logic [c_cw-1:0] c_one         = c_cw'(1);

    typedef enum logic [2:0] {
        S_WAIT_LOCK  = 3'd0,
        S_REL_DDR    = 3'd1,
        S_REL_CPU    = 3'd2,
        S_REL_PERIPH = 3'd3,
        S_RUN        = 3'd4,
        S_LOSS       = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [c_cw-1:0] r_cnt;
    logic [c_cw-1:0] w_cnt_next;
    logic [c_cw-1:0] r_tcnt;
    logic [c_cw-1:0] w_tcnt_next;
    logic            r_tmo_hit;
    logic            r_pll_s1;
    logic            r_pll_s2;
    logic            r_dcm_s1;
    logic            r_dcm_s2;
    logic            w_lock;
    logic            w_sw_take;

    always_comb begin
        w_lock       = r_pll_s2 & r_dcm_s2;
        w_state_next = r_state;
        w_sw_take    = 1'b0;
        case (r_state)
            S_WAIT_LOCK: begin
                if (w_lock && (r_cnt == c_stable_last)) begin
                    w_state_next = S_REL_DDR;
                end
            end
            S_REL_DDR, S_REL_CPU, S_REL_PERIPH, S_RUN: begin
                // Lock loss outranks a software request so the event is counted
                if (!w_lock) begin
                    w_state_next = S_LOSS;
                end else if (sw_rst_req_i) begin
                    w_state_next = S_WAIT_LOCK;
                    w_sw_take    = 1'b1;
                end else if (r_cnt == c_stage_last) begin
                    case (r_state)
                        S_REL_DDR:    w_state_next = S_REL_CPU;
                        S_REL_CPU:    w_state_next = S_REL_PERIPH;
                        S_REL_PERIPH: w_state_next = S_RUN;
                        default:      w_state_next = r_state;
                    endcase
                end
            end
            default: w_state_next = S_WAIT_LOCK;
        endcase

        // Shared stage counter restarts from zero on every state entry
        w_cnt_next = '0;
        if (w_state_next == r_state) begin
            case (r_state)
                S_WAIT_LOCK:                         w_cnt_next = w_lock ? (r_cnt + c_one) : '0;
                S_REL_DDR, S_REL_CPU, S_REL_PERIPH:  w_cnt_next = r_cnt + c_one;
                default:                             w_cnt_next = '0;
            endcase
        end

        w_tcnt_next = '0;
        if ((r_state == S_WAIT_LOCK) && (w_state_next == S_WAIT_LOCK)) begin
            w_tcnt_next = (r_tcnt == c_tmo_last) ? r_tcnt : (r_tcnt + c_one);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_pll_s1       <= 1'b0;
            r_pll_s2       <= 1'b0;
            r_dcm_s1       <= 1'b0;
            r_dcm_s2       <= 1'b0;
            r_state        <= S_WAIT_LOCK;
            r_cnt          <= '0;
            r_tcnt         <= '0;
            r_tmo_hit      <= 1'b0;
            ddr2_rst_o     <= 1'b1;
            cpu_rst_o      <= 1'b1;
            periph_rst_o   <= 1'b1;
            rst_done_o     <= 1'b0;
            lock_timeout_o <= 1'b0;
            loss_cnt_o     <= 8'd0;
        end else begin
            r_pll_s1  <= pll_locked_i;
            r_pll_s2  <= r_pll_s1;
            r_dcm_s1  <= dcm_locked_i;
            r_dcm_s2  <= r_dcm_s1;
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_tcnt    <= w_tcnt_next;
            r_tmo_hit <= (r_state == S_WAIT_LOCK) && (r_tcnt == c_tmo_last);
            lock_timeout_o <= lock_timeout_o | r_tmo_hit;

            // A software request reasserts the resets at once, ahead of the state decode
            if (w_sw_take) begin
                ddr2_rst_o   <= 1'b1;
                cpu_rst_o    <= 1'b1;
                periph_rst_o <= 1'b1;
                rst_done_o   <= 1'b0;
            end else begin
                ddr2_rst_o   <= !(r_state inside {S_REL_DDR, S_REL_CPU, S_REL_PERIPH, S_RUN});
                cpu_rst_o    <= !(r_state inside {S_REL_CPU, S_REL_PERIPH, S_RUN});
                periph_rst_o <= !(r_state inside {S_REL_PERIPH, S_RUN});
                rst_done_o   <= (r_state == S_RUN);
            end

            if ((w_state_next == S_LOSS) && (r_state != S_LOSS) && (loss_cnt_o != 8'hFF)) begin
                loss_cnt_o <= loss_cnt_o + 8'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rst_seq.sv
// ============================================================================
//  Module   : tb_rst_seq
//  Brief    : Directed self-checking bench for rst_seq (8/4/32 cycle config)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rst_seq;

    logic       clk;
    logic       rst;
    logic       pll;
    logic       dcm;
    logic       sw;
    logic       ddr2_rst;
    logic       cpu_rst;
    logic       periph_rst;
    logic       rst_done;
    logic       lock_tmo;
    logic [7:0] loss_cnt;

    int errors = 0;
    int checks = 0;
    int stuck  = 0;

    rst_seq #(
        .STABLE_CYCLES(8),
        .STAGE_CYCLES (4),
        .LOCK_TIMEOUT (32)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .pll_locked_i  (pll),
        .dcm_locked_i  (dcm),
        .sw_rst_req_i  (sw),
        .ddr2_rst_o    (ddr2_rst),
        .cpu_rst_o     (cpu_rst),
        .periph_rst_o  (periph_rst),
        .rst_done_o    (rst_done),
        .lock_timeout_o(lock_tmo),
        .loss_cnt_o    (loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle so inputs change away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && !rst_done; i++) tick();
        chk("done_return", {15'd0, rst_done}, 16'd1);
    endtask

    initial begin
        rst = 1'b1; pll = 1'b0; dcm = 1'b0; sw = 1'b0;
        repeat (3) tick();
        chk("rst_ddr2",   {15'd0, ddr2_rst},   16'd1);
        chk("rst_cpu",    {15'd0, cpu_rst},    16'd1);
        chk("rst_periph", {15'd0, periph_rst}, 16'd1);
        chk("rst_done",   {15'd0, rst_done},   16'd0);
        chk("rst_tmo",    {15'd0, lock_tmo},   16'd0);
        chk("rst_loss",   {8'd0, loss_cnt},    16'd0);

        // Timeout: reset falls after edge 0, locks stay low
        tick(); rst = 1'b0;
        repeat (32) tick();
        chk("tmo_e32", {15'd0, lock_tmo}, 16'd0);
        tick();
        chk("tmo_e33", {15'd0, lock_tmo}, 16'd1);

        // Normal bring-up: locks rise after edge 0
        tick(); pll = 1'b1; dcm = 1'b1;
        repeat (10) tick();
        chk("ddr2_e10", {15'd0, ddr2_rst}, 16'd1);
        tick();
        chk("ddr2_e11", {15'd0, ddr2_rst}, 16'd0);
        chk("cpu_e11",  {15'd0, cpu_rst},  16'd1);
        repeat (3) tick();
        chk("cpu_e14", {15'd0, cpu_rst}, 16'd1);
        tick();
        chk("cpu_e15", {15'd0, cpu_rst}, 16'd0);
        repeat (3) tick();
        chk("periph_e18", {15'd0, periph_rst}, 16'd1);
        tick();
        chk("periph_e19", {15'd0, periph_rst}, 16'd0);
        repeat (3) tick();
        chk("done_e22", {15'd0, rst_done}, 16'd0);
        tick();
        chk("done_e23", {15'd0, rst_done}, 16'd1);
        chk("tmo_sticky", {15'd0, lock_tmo}, 16'd1);

        // Mid-sequence reset clears everything including the sticky flag
        rst = 1'b1;
        tick();
        rst = 1'b0; pll = 1'b0; dcm = 1'b0;
        chk("midrst_tmo",  {15'd0, lock_tmo}, 16'd0);
        chk("midrst_ddr2", {15'd0, ddr2_rst}, 16'd1);
        chk("midrst_done", {15'd0, rst_done}, 16'd0);

        // Lock glitch: dcm low one cycle while stable count is 5
        tick(); pll = 1'b1; dcm = 1'b1;
        repeat (5) tick(); dcm = 1'b0;
        tick(); dcm = 1'b1;
        repeat (10) tick();
        chk("glitch_ddr2_e16", {15'd0, ddr2_rst}, 16'd1);
        tick();
        chk("glitch_ddr2_e17", {15'd0, ddr2_rst}, 16'd0);
        repeat (12) tick();
        chk("glitch_done_e29", {15'd0, rst_done}, 16'd1);

        // Software reset in RUN
        sw = 1'b1;
        tick(); sw = 1'b0;
        chk("sw_ddr2",   {15'd0, ddr2_rst},   16'd1);
        chk("sw_cpu",    {15'd0, cpu_rst},    16'd1);
        chk("sw_periph", {15'd0, periph_rst}, 16'd1);
        chk("sw_done",   {15'd0, rst_done},   16'd0);
        chk("sw_loss",   {8'd0, loss_cnt},    16'd0);
        repeat (20) tick();
        chk("sw_done_e20", {15'd0, rst_done}, 16'd0);
        tick();
        chk("sw_done_e21", {15'd0, rst_done}, 16'd1);

        // Lock loss in RUN
        pll = 1'b0;
        repeat (4) tick();
        chk("loss_ddr2",   {15'd0, ddr2_rst},   16'd1);
        chk("loss_cpu",    {15'd0, cpu_rst},    16'd1);
        chk("loss_periph", {15'd0, periph_rst}, 16'd1);
        chk("loss_cnt1",   {8'd0, loss_cnt},    16'd1);
        chk("loss_done",   {15'd0, rst_done},   16'd0);
        pll = 1'b1;
        wait_done();

        // Software request in the very cycle lock loss is seen
        pll = 1'b0;
        repeat (2) tick();
        sw = 1'b1;
        tick(); sw = 1'b0;
        chk("both_loss_cnt", {8'd0, loss_cnt}, 16'd2);
        tick();
        chk("both_ddr2", {15'd0, ddr2_rst}, 16'd1);
        pll = 1'b1;
        wait_done();

        // Repeated losses saturate the counter
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 50 && ddr2_rst; i++) tick();
            if (ddr2_rst) stuck++;
            pll = 1'b0;
            repeat (4) tick();
            pll = 1'b1;
        end
        chk("loss_loop_stuck", stuck[15:0], 16'd0);
        chk("loss_sat", {8'd0, loss_cnt}, 16'd255);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("final_rst_loss", {8'd0, loss_cnt}, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 Parameter STABLE_CYCLES, default 1024: consecutive cycles both lock inputs must be high before any reset is released.
REQ-002 Parameter STAGE_CYCLES, default 16: cycles between successive reset-release stages.
REQ-003 Parameter LOCK_TIMEOUT, default 65536: cycles in WAIT_LOCK before lock_timeout_o is flagged.
REQ-004 Port wb_clk_i, input, 1: single clock; all logic is on its rising edge.
REQ-005 Port wb_rst_i, input, 1: reset, synchronous and active-high.
REQ-006 Port pll_locked_i, input, 1: PLL lock, asynchronous to wb_clk_i.
REQ-007 Port dcm_locked_i, input, 1: DCM lock, asynchronous to wb_clk_i.
REQ-008 Port sw_rst_req_i, input, 1: single-cycle software reset request.
REQ-009 Port ddr2_rst_o, output, 1: memory-interface reset, active-high, released first.
REQ-010 Port cpu_rst_o, output, 1: CPU/bus reset, active-high, released second.
REQ-011 Port periph_rst_o, output, 1: peripheral reset, active-high, released third.
REQ-012 Port rst_done_o, output, 1: high only in RUN.
REQ-013 Port lock_timeout_o, output, 1: sticky flag, lock not achieved within LOCK_TIMEOUT.
REQ-014 Port loss_cnt_o, output, 8: saturating count of lock-loss events.

Function
REQ-015 pll_locked_i and dcm_locked_i shall each pass through a 2-flop synchronizer; "lock" means both synchronized values are high.
REQ-016 FSM states: WAIT_LOCK, REL_DDR, REL_CPU, REL_PERIPH, RUN, LOSS.
- One shared stage counter; it clears on every state entry.
REQ-017 In WAIT_LOCK:
- If lock is high, the counter increments; any low lock clears it.
- Go to REL_DDR on the cycle the counter equals STABLE_CYCLES-1 with lock high.
REQ-018 In REL_DDR, REL_CPU and REL_PERIPH, the FSM shall advance to the next state (REL_CPU, REL_PERIPH, RUN) when the counter equals STAGE_CYCLES-1.
REQ-019 All outputs shall be registered; output behaviour per state:
- ddr2_rst_o is low in REL_DDR and every later stage.
- cpu_rst_o is low from REL_CPU onward.
- periph_rst_o is low from REL_PERIPH onward.
- rst_done_o is high in RUN only.
- Each change is visible one edge after the state is entered.
REQ-020 Lock going low in any state other than WAIT_LOCK shall cause:
- a transition to LOSS, with all three resets asserted on the next edge;
- loss_cnt_o incremented once, saturating at 255;
- the next state is WAIT_LOCK.
REQ-021 sw_rst_req_i high in RUN, REL_* or LOSS shall:
- assert all three resets and enter WAIT_LOCK;
- leave loss_cnt_o unchanged.
- In WAIT_LOCK, the request shall be ignored.
REQ-022 If lock loss and sw_rst_req_i occur in the same cycle, lock loss shall take priority and the event is counted.
REQ-023 A separate timeout counter shall run only in WAIT_LOCK and clear on leaving it.
- When it reaches LOCK_TIMEOUT-1, lock_timeout_o is set; it stays set until wb_rst_i.
- The FSM remains in WAIT_LOCK.
- The timeout counter saturates at LOCK_TIMEOUT-1.
REQ-024 Counter widths shall be $clog2 of the largest parameter; no wrap-around is permitted.

Reset
REQ-025 While wb_rst_i is high, on each edge:
- state becomes WAIT_LOCK and all counters are cleared;
- ddr2_rst_o, cpu_rst_o and periph_rst_o are set to 1;
- rst_done_o, lock_timeout_o and loss_cnt_o are set to 0;
- synchronizer flops are set to 0.
REQ-026 A reset applied mid-sequence shall behave as REQ-025 on the next edge, with no partial-stage state retained.

Verification (STABLE_CYCLES=8, STAGE_CYCLES=4, LOCK_TIMEOUT=32)
REQ-027 Normal bring-up: both locks rise at edge 0 after reset. Required response:
- ddr2_rst_o falls at edge 11.
- cpu_rst_o falls at edge 15.
- periph_rst_o falls at edge 19.
- rst_done_o rises at edge 23.
REQ-028 Lock glitch: dcm_locked_i is low for 1 cycle at stable count 5 -> counter clears, and release is delayed by the full 8 cycles from the restored lock.
REQ-029 Lock loss in RUN: pll_locked_i falls. Required response:
- all resets are 1 within 4 edges;
- loss_cnt_o=1 and rst_done_o=0;
- the sequence restarts once lock returns.
- Repeating 300 losses leaves loss_cnt_o=255.
REQ-030 Timeout: locks held low -> lock_timeout_o=1 at edge 33 after reset; it stays 1 after a later successful bring-up and clears only on wb_rst_i.
REQ-031 Software reset in RUN: sw_rst_req_i pulsed -> all resets are 1 next edge, loss_cnt_o unchanged, and full re-release follows.
- The same pulse in the same cycle as lock loss increments loss_cnt_o.
